// File: rtl/mnist_pkg.sv
// Shared types and constants for the MNIST inference datapath and its sequencer.
package mnist_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      L1_START = 3'd1,
      L1_WAIT  = 3'd2,
      L2_START = 3'd3,
      L2_WAIT  = 3'd4,
      RESP     = 3'd5
   } state_t;

   localparam logic [3:0] CLASS_ERR = 4'hF;

   localparam int L1_IN_DIM  = 784;
   localparam int L1_OUT_DIM = 32;
   localparam int L2_OUT_DIM = 10;
   localparam int ACC_WIDTH  = 32;

endpackage

// File: rtl/mnist_watchdog.sv
// Clearable up-counter shared by both layer wait states; flags the first wait
// cycle and the cycle on which the selected limit is reached.
module mnist_watchdog #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             first,
   output logic             timeout
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear)
         count <= '0;
      else if (enable && (count != '1))
         count <= count + 1'b1;
   end

   // count holds the number of wait cycles already completed, so the
   // limit-th wait cycle is the one where count == limit-1.
   always_comb begin
      first   = (count == '0);
      timeout = (count >= (limit - 1'b1));
   end

endmodule

// File: rtl/mnist_inference_sequencer.sv
// Sequences one inference through layer 1 then layer 2 with per-layer
// watchdogs and returns class, error status and latency over valid/ready.
module mnist_inference_sequencer
   import mnist_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int L1_TIMEOUT = 4000,
   parameter int L2_TIMEOUT = 400,
   parameter int CLASS_W    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   output logic               l1_start,
   input  logic               l1_done,
   output logic               l2_start,
   input  logic               l2_done,
   input  logic [CLASS_W-1:0] l2_class,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [CLASS_W-1:0] resp_class,
   output logic               resp_error,
   output logic               resp_err_layer,
   output logic [CNT_W-1:0]   resp_cycles,
   output logic               busy
);

   state_t           state;
   logic [CNT_W-1:0] lat;
   logic [CNT_W-1:0] lat_inc;
   logic             wd_clear;
   logic             wd_enable;
   logic [CNT_W-1:0] wd_limit;
   logic             wd_first;
   logic             wd_timeout;

   always_comb begin
      lat_inc   = (lat == '1) ? lat : lat + 1'b1;
      wd_clear  = (state == L1_START) || (state == L2_START);
      wd_enable = (state == L1_WAIT) || (state == L2_WAIT);
      wd_limit  = (state == L2_WAIT) ? CNT_W'(L2_TIMEOUT) : CNT_W'(L1_TIMEOUT);
   end

   mnist_watchdog #(.CNT_W(CNT_W)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .limit   (wd_limit),
      .first   (wd_first),
      .timeout (wd_timeout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         req_ready      <= 1'b1;
         l1_start       <= 1'b0;
         l2_start       <= 1'b0;
         resp_valid     <= 1'b0;
         resp_class     <= '0;
         resp_error     <= 1'b0;
         resp_err_layer <= 1'b0;
         resp_cycles    <= '0;
         busy           <= 1'b0;
         lat            <= '0;
      end else begin
         l1_start <= 1'b0;
         l2_start <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  state     <= L1_START;
                  lat       <= CNT_W'(1);
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
                  l1_start  <= 1'b1;
               end
            end
            L1_START: begin
               lat   <= lat_inc;
               state <= L1_WAIT;
            end
            // done is ignored on the first wait cycle and beats a same-cycle timeout
            L1_WAIT: begin
               lat <= lat_inc;
               if (l1_done && !wd_first) begin
                  state    <= L2_START;
                  l2_start <= 1'b1;
               end else if (wd_timeout) begin
                  state          <= RESP;
                  resp_valid     <= 1'b1;
                  resp_error     <= 1'b1;
                  resp_err_layer <= 1'b0;
                  resp_class     <= CLASS_W'(CLASS_ERR);
                  resp_cycles    <= lat_inc;
               end
            end
            L2_START: begin
               lat   <= lat_inc;
               state <= L2_WAIT;
            end
            L2_WAIT: begin
               lat <= lat_inc;
               if (l2_done && !wd_first) begin
                  state          <= RESP;
                  resp_valid     <= 1'b1;
                  resp_error     <= 1'b0;
                  resp_err_layer <= 1'b0;
                  resp_class     <= l2_class;
                  resp_cycles    <= lat_inc;
               end else if (wd_timeout) begin
                  state          <= RESP;
                  resp_valid     <= 1'b1;
                  resp_error     <= 1'b1;
                  resp_err_layer <= 1'b1;
                  resp_class     <= CLASS_W'(CLASS_ERR);
                  resp_cycles    <= lat_inc;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mnist_inference_sequencer.sv
// Directed bench for mnist_inference_sequencer: nominal run, guard cycle,
// both watchdogs, done/timeout tie, backpressure and mid-run reset.
module tb_mnist_inference_sequencer;

   localparam int CNT_W   = 16;
   localparam int CLASS_W = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic               req_valid;
   logic               req_ready;
   logic               l1_start;
   logic               l1_done;
   logic               l2_start;
   logic               l2_done;
   logic [CLASS_W-1:0] l2_class;
   logic               resp_valid;
   logic               resp_ready;
   logic [CLASS_W-1:0] resp_class;
   logic               resp_error;
   logic               resp_err_layer;
   logic [CNT_W-1:0]   resp_cycles;
   logic               busy;

   int checks = 0;
   int errors = 0;
   int l1_hi  = 0;
   int l2_hi  = 0;

   mnist_inference_sequencer #(
      .CNT_W      (CNT_W),
      .L1_TIMEOUT (4000),
      .L2_TIMEOUT (400),
      .CLASS_W    (CLASS_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .l1_start       (l1_start),
      .l1_done        (l1_done),
      .l2_start       (l2_start),
      .l2_done        (l2_done),
      .l2_class       (l2_class),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_class     (resp_class),
      .resp_error     (resp_error),
      .resp_err_layer (resp_err_layer),
      .resp_cycles    (resp_cycles),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // Cycles with each start asserted; one pulse per run means +1 per run.
   always @(negedge clk) begin
      if (l1_start) l1_hi++;
      if (l2_start) l2_hi++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(input int limit, output int n);
      n = -1;
      for (int k = 1; k <= limit; k++) begin
         tick();
         if (resp_valid === 1'b1) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic handshake;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; req_valid = 1'b0; l1_done = 1'b0; l2_done = 1'b0;
      l2_class = '0; resp_ready = 1'b0;
      repeat (3) tick();
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || l1_start !== 1'b0 || l2_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl req_ready=%b busy=%b resp_valid=%b l1_start=%b l2_start=%b want 1 0 0 0 0",
                  req_ready, busy, resp_valid, l1_start, l2_start);
      end
      checks++;
      if (resp_class !== 4'h0 || resp_error !== 1'b0 || resp_err_layer !== 1'b0 || resp_cycles !== 16'd0) begin
         errors++;
         $display("FAIL reset_resp class=%h err=%b layer=%b cycles=%0d want 0 0 0 0",
                  resp_class, resp_error, resp_err_layer, resp_cycles);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (req_ready !== 1'b1 || l1_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_release req_ready=%b l1_start=%b want 1 0", req_ready, l1_start);
      end
   endtask

   task automatic test_nominal;
      int b1, b2, n;
      b1 = l1_hi; b2 = l2_hi;
      req_valid = 1'b1;
      tick();                        // c1: L1_START
      req_valid = 1'b0;
      checks++;
      if (l1_start !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL nominal_accept l1_start=%b busy=%b req_ready=%b want 1 1 0", l1_start, busy, req_ready);
      end
      repeat (100) tick();           // c101: 100th L1 wait cycle
      l1_done = 1'b1;
      tick();                        // c102: L2_START
      l1_done = 1'b0;
      checks++;
      if (l2_start !== 1'b1) begin
         errors++;
         $display("FAIL nominal_l2_start got %b want 1", l2_start);
      end
      repeat (20) tick();            // c122: 20th L2 wait cycle
      l2_done = 1'b1; l2_class = 4'd7;
      wait_resp(10, n);
      l2_done = 1'b0;
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL nominal_resp_delay got %0d want 1", n);
      end
      checks++;
      if (resp_class !== 4'd7 || resp_error !== 1'b0) begin
         errors++;
         $display("FAIL nominal_resp class=%h err=%b want 7 0", resp_class, resp_error);
      end
      // 1 (accept) + 1 start + 100 waits + 1 start + 20 waits
      checks++;
      if (resp_cycles !== 16'd123) begin
         errors++;
         $display("FAIL nominal_cycles got %0d want 123", resp_cycles);
      end
      checks++;
      if (l1_hi - b1 != 1 || l2_hi - b2 != 1) begin
         errors++;
         $display("FAIL nominal_pulses l1=%0d l2=%0d want 1 1", l1_hi - b1, l2_hi - b2);
      end
      handshake();
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || resp_class !== 4'd7) begin
         errors++;
         $display("FAIL nominal_done resp_valid=%b req_ready=%b busy=%b class=%h want 0 1 0 7",
                  resp_valid, req_ready, busy, resp_class);
      end
   endtask

   task automatic test_stale_done;
      int n;
      l1_done = 1'b1;
      req_valid = 1'b1;
      tick();                        // c1
      req_valid = 1'b0;
      tick();                        // c2: guard cycle
      tick();                        // c3
      checks++;
      if (l2_start !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL stale_guard l2_start=%b busy=%b want 0 1", l2_start, busy);
      end
      tick();                        // c4
      checks++;
      if (l2_start !== 1'b1) begin
         errors++;
         $display("FAIL stale_second l2_start=%b want 1", l2_start);
      end
      l1_done = 1'b0; l2_done = 1'b1; l2_class = 4'd3;
      wait_resp(10, n);
      l2_done = 1'b0;
      checks++;
      if (n != 3 || resp_class !== 4'd3 || resp_error !== 1'b0 || resp_cycles !== 16'd7) begin
         errors++;
         $display("FAIL stale_resp delay=%0d class=%h err=%b cycles=%0d want 3 3 0 7",
                  n, resp_class, resp_error, resp_cycles);
      end
      handshake();
   endtask

   task automatic test_l1_hang;
      int b2, n;
      b2 = l2_hi;
      req_valid = 1'b1;
      tick();                        // c1
      req_valid = 1'b0;
      wait_resp(4100, n);
      checks++;
      if (n != 4001) begin
         errors++;
         $display("FAIL l1_hang_delay got %0d want 4001", n);
      end
      checks++;
      if (resp_error !== 1'b1 || resp_err_layer !== 1'b0 || resp_class !== 4'hF || resp_cycles !== 16'd4002) begin
         errors++;
         $display("FAIL l1_hang_resp err=%b layer=%b class=%h cycles=%0d want 1 0 f 4002",
                  resp_error, resp_err_layer, resp_class, resp_cycles);
      end
      checks++;
      if (l2_hi != b2) begin
         errors++;
         $display("FAIL l1_hang_no_l2 l2 pulses=%0d want 0", l2_hi - b2);
      end
      handshake();
   endtask

   task automatic test_l2_simultaneous;
      l1_done = 1'b1;
      req_valid = 1'b1;
      tick();                        // c1
      req_valid = 1'b0;
      repeat (3) tick();             // c4: L2_START
      l1_done = 1'b0;
      repeat (400) tick();           // c404: 400th L2 wait cycle
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL l2_tie_pre resp_valid=%b busy=%b want 0 1", resp_valid, busy);
      end
      l2_done = 1'b1; l2_class = 4'd9;
      tick();                        // c405
      l2_done = 1'b0;
      checks++;
      if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_class !== 4'd9 || resp_cycles !== 16'd405) begin
         errors++;
         $display("FAIL l2_tie_resp valid=%b err=%b class=%h cycles=%0d want 1 0 9 405",
                  resp_valid, resp_error, resp_class, resp_cycles);
      end
      handshake();
   endtask

   task automatic test_l2_hang;
      int n;
      l1_done = 1'b1;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (3) tick();             // c4: L2_START
      l1_done = 1'b0;
      wait_resp(500, n);
      checks++;
      if (n != 401 || resp_error !== 1'b1 || resp_err_layer !== 1'b1 || resp_class !== 4'hF || resp_cycles !== 16'd405) begin
         errors++;
         $display("FAIL l2_hang_resp delay=%0d err=%b layer=%b class=%h cycles=%0d want 401 1 1 f 405",
                  n, resp_error, resp_err_layer, resp_class, resp_cycles);
      end
      handshake();
   endtask

   task automatic test_backpressure;
      int n, b1;
      l1_done = 1'b1; l2_done = 1'b1; l2_class = 4'd5;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      wait_resp(20, n);
      l1_done = 1'b0; l2_done = 1'b0;
      checks++;
      if (n != 6 || resp_class !== 4'd5 || resp_cycles !== 16'd7) begin
         errors++;
         $display("FAIL bp_resp delay=%0d class=%h cycles=%0d want 6 5 7", n, resp_class, resp_cycles);
      end
      for (int i = 0; i < 50; i++) begin
         l2_class  = i[3:0];
         req_valid = i[0];
         tick();
         checks++;
         if (resp_valid !== 1'b1 || resp_class !== 4'd5 || resp_error !== 1'b0 || resp_err_layer !== 1'b0 ||
             resp_cycles !== 16'd7 || req_ready !== 1'b0 || l1_start !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d] valid=%b class=%h err=%b layer=%b cycles=%0d req_ready=%b l1_start=%b want 1 5 0 0 7 0 0",
                     i, resp_valid, resp_class, resp_error, resp_err_layer, resp_cycles, req_ready, l1_start);
         end
      end
      req_valid = 1'b0; l2_class = '0;
      handshake();
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release resp_valid=%b req_ready=%b want 0 1", resp_valid, req_ready);
      end
      b1 = l1_hi;
      repeat (2) tick();
      checks++;
      if (busy !== 1'b0 || l1_hi != b1) begin
         errors++;
         $display("FAIL bp_idle busy=%b new l1 pulses=%0d want 0 0", busy, l1_hi - b1);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      l1_done = 1'b1;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (3) tick();             // c4: L2_START
      l1_done = 1'b0;
      repeat (5) tick();             // inside L2_WAIT
      checks++;
      if (busy !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_pre busy=%b resp_valid=%b want 1 0", busy, resp_valid);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_class !== 4'h0 ||
          l1_start !== 1'b0 || l2_start !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_idle busy=%b req_ready=%b resp_valid=%b class=%h l1=%b l2=%b want 0 1 0 0 0 0",
                  busy, req_ready, resp_valid, resp_class, l1_start, l2_start);
      end
      tick();
      checks++;
      if (l1_start !== 1'b0 || l2_start !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_nopulse l1=%b l2=%b want 0 0", l1_start, l2_start);
      end
      l1_done = 1'b1; l2_done = 1'b1; l2_class = 4'd2;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      wait_resp(20, n);
      l1_done = 1'b0; l2_done = 1'b0;
      checks++;
      if (n != 6 || resp_class !== 4'd2 || resp_error !== 1'b0 || resp_cycles !== 16'd7) begin
         errors++;
         $display("FAIL rst_mid_rerun delay=%0d class=%h err=%b cycles=%0d want 6 2 0 7",
                  n, resp_class, resp_error, resp_cycles);
      end
      handshake();
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_stale_done();
      test_l1_hang();
      test_l2_simultaneous();
      test_l2_hang();
      test_backpressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
